usb_packet_buffer_controller: RTL and testbench
===============================================

Name: usb_packet_buffer_controller

Overview:
- Owns the USB receive packet buffer: a single-port RAM of DEPTH x 32 bits.
- Two requesters share it: the USB receiver, which writes decoded words, and the CPU MMIO port, which reads and writes words plus two control registers.
- Sequences buffer ownership between receiver and CPU, and raises the packet interrupt.
- Gives the receiver a registered accept/ignore decision, replacing the receiver's direct probe of core interrupt state.

Parameters:
DEPTH, 256, buffer depth in 32-bit words (power of 2)
INDEX_WIDTH, 8, log2(DEPTH)

Ports:
clock48  input  1  system clock, 48 MHz
reset_n  input  1  asynchronous, active-low reset
usb_write  input  1  receiver write strobe, one word
usb_write_index  input  INDEX_WIDTH  word index for usb_write
usb_write_data  input  32  word data
usb_packet_done  input  1  one-cycle pulse at end of packet
usb_accept  output  1  1 = receiver may start storing a packet
cpu_read  input  1  CPU read request, held until cpu_ready
cpu_write  input  1  CPU write request, held until cpu_ready
cpu_address  input  INDEX_WIDTH+1  bit[INDEX_WIDTH]=1 selects control regs, else buffer word
cpu_write_data  input  32  CPU write data
cpu_read_data  output  32  read data, valid while cpu_ready=1
cpu_ready  output  1  one-cycle completion pulse
interrupt  output  1  level interrupt: packet waiting for CPU

Behaviour:
- Reset (reset_n=0, async):
  - state=FREE, usb_accept=1, interrupt=0, cpu_ready=0, cpu_read_data=0.
  - length=0, dropped=0.
  - RAM contents are not reset.
- States:
  - FREE: usb_accept=1. usb_write -> RECEIVING. usb_packet_done with no prior write -> FULL, length=0.
  - RECEIVING: usb_accept=0. Each usb_write stores the word; length increments, saturating at DEPTH. usb_packet_done -> FULL.
  - FULL: usb_accept=0, interrupt=1. usb_write is dropped and does not touch RAM. usb_packet_done increments dropped (8-bit, saturating at 255). CPU release -> FREE.
- Length counts accepted writes, not the index. Out-of-order or repeated indices still count. Index wraps modulo DEPTH.
- length resets to 0 on every FREE->RECEIVING transition.
- usb_write and usb_packet_done in the same cycle: the word is stored and counted, then the state goes to FULL.
- Arbitration (one RAM access per cycle):
  - An accepted usb_write has priority.
  - A CPU buffer access in the same cycle is stalled one cycle. cpu_ready is delayed by 1.
  - Receiver writes are at most one per 128 cycles, so a CPU stall is bounded to 1 cycle.
- CPU timing:
  - A request sampled in cycle N (no conflict) gives cpu_ready=1 in N+1.
  - Read data comes from the RAM's registered output.
  - The CPU must deassert or issue a new request in the cycle after cpu_ready. A request still held then counts as a new access.
  - cpu_read and cpu_write both high: write wins.
  - The CPU may access the buffer in any state; ownership is advisory for the buffer.
- Control registers (bit[INDEX_WIDTH]=1; low bits select):
  - 0 STATUS (read-only): bit0=FULL, bit1=RECEIVING, [15:8]=dropped, [16+INDEX_WIDTH:16]=length, others 0. Writes are ignored but still return cpu_ready.
  - 1 CONTROL (write): bit0=1 releases (FULL->FREE, interrupt clears next cycle; ignored in other states); bit1=1 clears dropped. Reads return 0.
  - Other offsets read 0; writes are ignored.
  - Control accesses never conflict with USB; they always take 1 cycle.
- Simultaneous release and usb_packet_done in FULL: release takes effect (state FREE) and dropped increments.
- Simultaneous release and usb_write in FULL: the write is dropped and the state becomes FREE.
- usb_accept and interrupt are registered outputs that follow the state.
- reset_n asserted mid-packet aborts the packet. The receiver sees usb_accept=1 after release.

Test Plan:
- Reset, then usb_write indices 0..3 with data A0..A3, then usb_packet_done -> interrupt=1, usb_accept=0, STATUS reads 0x00040001; buffer reads of 0..3 return A0..A3, each cpu_ready one cycle after the request.
- In FULL, issue 3 writes + usb_packet_done; then read STATUS -> dropped=1, length unchanged at 4, buffer word 0 still A0. Write CONTROL=0x1 -> interrupt=0 and usb_accept=1 on the next cycle; STATUS=0x00040100.
- CPU read of word 5 in the same cycle as usb_write index 5 data 0xDEADBEEF (RECEIVING) -> cpu_ready after 2 cycles, data=0xDEADBEEF.
- usb_packet_done in FREE with no writes -> FULL, length=0, interrupt=1. Release and usb_packet_done in the same cycle -> FREE, dropped=1. CONTROL=0x2 -> dropped=0.
- 300 usb_writes then done -> length saturates at 256. Assert reset_n=0 mid-RECEIVING -> immediately FREE, interrupt=0, STATUS=0.

Source files
------------

// File: rtl/usb_packet_buffer_controller.sv
`default_nettype none
// ============================================================================
// Module   : usb_packet_buffer_controller
// Purpose  : USB receive packet buffer with receiver/CPU arbitration,
//            ownership sequencing and packet interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module usb_packet_buffer_controller #(
  parameter int DEPTH       = 256,
  parameter int INDEX_WIDTH = 8
) (
  input  logic                   clock48,
  input  logic                   reset_n,
  input  logic                   usb_write,
  input  logic [INDEX_WIDTH-1:0] usb_write_index,
  input  logic [31:0]            usb_write_data,
  input  logic                   usb_packet_done,
  output logic                   usb_accept,
  input  logic                   cpu_read,
  input  logic                   cpu_write,
  input  logic [INDEX_WIDTH:0]   cpu_address,
  input  logic [31:0]            cpu_write_data,
  output logic [31:0]            cpu_read_data,
  output logic                   cpu_ready,
  output logic                   interrupt
);

  localparam logic [INDEX_WIDTH:0] c_LEN_MAX = (INDEX_WIDTH+1)'(DEPTH);
  localparam logic [INDEX_WIDTH:0] c_LEN_ONE = (INDEX_WIDTH+1)'(1);

  typedef enum logic [1:0] {
    S_FREE      = 2'd0,
    S_RECEIVING = 2'd1,
    S_FULL      = 2'd2
  } state_t;

  state_t               r_state, w_state_next;
  logic [INDEX_WIDTH:0] r_length, w_length_next;
  logic [7:0]           r_dropped, w_dropped_next;
  logic                 r_usb_accept, r_interrupt, r_cpu_ready, r_rd_sel_ram;
  logic [31:0]          r_ctrl_q, r_ram_q;
  logic [31:0]          r_mem [DEPTH];

  logic                   w_usb_acc, w_cpu_req, w_cpu_ctrl, w_cpu_svc;
  logic                   w_ctrl_wr, w_release, w_clr_drop, w_stat_rd;
  logic                   w_ram_we, w_ram_re;
  logic [INDEX_WIDTH-1:0] w_ram_addr, w_cpu_offset;
  logic [31:0]            w_ram_wdata, w_status;

  assign w_usb_acc    = usb_write && (r_state != S_FULL);
  // The cycle carrying cpu_ready still sees the old request held; it is not a new access.
  assign w_cpu_req    = (cpu_read || cpu_write) && !r_cpu_ready;
  assign w_cpu_ctrl   = cpu_address[INDEX_WIDTH];
  assign w_cpu_offset = cpu_address[INDEX_WIDTH-1:0];
  assign w_cpu_svc    = w_cpu_req && (w_cpu_ctrl || !w_usb_acc);
  assign w_ctrl_wr    = w_cpu_svc && w_cpu_ctrl && cpu_write
                        && (w_cpu_offset == INDEX_WIDTH'(1));
  assign w_release    = w_ctrl_wr && cpu_write_data[0];
  assign w_clr_drop   = w_ctrl_wr && cpu_write_data[1];
  assign w_stat_rd    = w_cpu_ctrl && !cpu_write && (w_cpu_offset == '0);

  always_comb begin
    w_status                       = '0;
    w_status[0]                    = (r_state == S_FULL);
    w_status[1]                    = (r_state == S_RECEIVING);
    w_status[15:8]                 = r_dropped;
    w_status[16 +: INDEX_WIDTH+1]  = r_length;
  end

  always_comb begin
    w_state_next   = r_state;
    w_length_next  = r_length;
    w_dropped_next = r_dropped;
    unique case (r_state)
      S_FREE: begin
        if (usb_write) begin
          w_length_next = c_LEN_ONE;
          w_state_next  = usb_packet_done ? S_FULL : S_RECEIVING;
        end else if (usb_packet_done) begin
          w_length_next = '0;
          w_state_next  = S_FULL;
        end
      end
      S_RECEIVING: begin
        if (usb_write && (r_length != c_LEN_MAX)) w_length_next = r_length + 1'b1;
        if (usb_packet_done) w_state_next = S_FULL;
      end
      S_FULL: begin
        if (usb_packet_done && (r_dropped != 8'hFF)) w_dropped_next = r_dropped + 8'd1;
        if (w_release) w_state_next = S_FREE;
      end
      default: w_state_next = S_FREE;
    endcase
    if (w_clr_drop) w_dropped_next = '0;
  end

  always_ff @(posedge clock48 or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_FREE;
      r_length     <= '0;
      r_dropped    <= '0;
      r_usb_accept <= 1'b1;
      r_interrupt  <= 1'b0;
      r_cpu_ready  <= 1'b0;
      r_rd_sel_ram <= 1'b0;
      r_ctrl_q     <= '0;
    end else begin
      r_state      <= w_state_next;
      r_length     <= w_length_next;
      r_dropped    <= w_dropped_next;
      r_usb_accept <= (w_state_next == S_FREE);
      r_interrupt  <= (w_state_next == S_FULL);
      r_cpu_ready  <= w_cpu_svc;
      if (w_cpu_svc) begin
        r_rd_sel_ram <= !w_cpu_ctrl && !cpu_write;
        r_ctrl_q     <= w_stat_rd ? w_status : '0;
      end
    end
  end

  // Single-port RAM: an accepted receiver write owns the port this cycle.
  assign w_ram_we    = w_usb_acc || (w_cpu_svc && !w_cpu_ctrl && cpu_write);
  assign w_ram_re    = w_cpu_svc && !w_cpu_ctrl && !cpu_write;
  assign w_ram_addr  = w_usb_acc ? usb_write_index : w_cpu_offset;
  assign w_ram_wdata = w_usb_acc ? usb_write_data  : cpu_write_data;

  always_ff @(posedge clock48) begin
    if (w_ram_we) r_mem[w_ram_addr] <= w_ram_wdata;
    if (w_ram_re) r_ram_q <= r_mem[w_ram_addr];
  end

  assign usb_accept    = r_usb_accept;
  assign interrupt     = r_interrupt;
  assign cpu_ready     = r_cpu_ready;
  assign cpu_read_data = r_rd_sel_ram ? r_ram_q : r_ctrl_q;

endmodule
`default_nettype wire

// File: tb/tb_usb_packet_buffer_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_packet_buffer_controller
// Purpose  : Self-checking bench: vector table, directed corner sequences and
//            randomized operations against a behavioural buffer model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_packet_buffer_controller;
  localparam int DEPTH = 256;
  localparam int IW    = 8;

  logic          clock48 = 1'b0;
  logic          reset_n = 1'b0;
  logic          usb_write = 1'b0;
  logic [IW-1:0] usb_write_index = '0;
  logic [31:0]   usb_write_data = '0;
  logic          usb_packet_done = 1'b0;
  logic          usb_accept;
  logic          cpu_read = 1'b0;
  logic          cpu_write = 1'b0;
  logic [IW:0]   cpu_address = '0;
  logic [31:0]   cpu_write_data = '0;
  logic [31:0]   cpu_read_data;
  logic          cpu_ready;
  logic          interrupt;

  always #5 clock48 = ~clock48;

  usb_packet_buffer_controller #(.DEPTH(DEPTH), .INDEX_WIDTH(IW)) dut (
    .clock48(clock48), .reset_n(reset_n),
    .usb_write(usb_write), .usb_write_index(usb_write_index),
    .usb_write_data(usb_write_data), .usb_packet_done(usb_packet_done),
    .usb_accept(usb_accept),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_address(cpu_address),
    .cpu_write_data(cpu_write_data), .cpu_read_data(cpu_read_data),
    .cpu_ready(cpu_ready), .interrupt(interrupt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock48);
    #1;
  endtask

  // Full request/ready handshake followed by one idle cycle.
  task automatic cpu_xfer(input logic wr, input logic [IW:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat);
    cpu_write = wr; cpu_read = !wr; cpu_address = addr; cpu_write_data = wd;
    lat = 0;
    do begin step(); lat++; end while (!cpu_ready && lat < 6);
    rd = cpu_read_data;
    cpu_read = 1'b0; cpu_write = 1'b0;
    step();
  endtask

  // ---------------- behavioural model (0 FREE, 1 RECEIVING, 2 FULL) --------
  int          m_state, m_len, m_drop;
  logic [31:0] m_mem [DEPTH];

  function automatic void m_usb(input bit w, input int idx, input logic [31:0] d,
                                input bit dn, input bit rel);
    int s0;
    s0 = m_state;
    if (w && s0 != 2) begin
      m_mem[idx] = d;
      if (s0 == 0) m_len = 1;
      else if (m_len < DEPTH) m_len++;
      m_state = 1;
    end
    if (dn) begin
      if (s0 == 2) begin
        if (m_drop < 255) m_drop++;
      end else begin
        if (s0 == 0 && !w) m_len = 0;
        m_state = 2;
      end
    end
    if (rel && s0 == 2) m_state = 0;
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = '0;
    s[0]     = (m_state == 2);
    s[1]     = (m_state == 1);
    s[15:8]  = 8'(m_drop);
    s[24:16] = 9'(m_len);
    return s;
  endfunction

  // ---------------- vector table -------------------------------------------
  typedef struct {
    logic          uw;
    logic [IW-1:0] idx;
    logic [31:0]   ud;
    logic          done, rd, wr;
    logic [IW:0]   addr;
    logic [31:0]   wd;
    logic          e_acc, e_int, e_rdy, chk_d;
    logic [31:0]   e_d;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int uw, input int idx, input logic [31:0] ud, input int done,
                              input int rd, input int wr, input int addr, input logic [31:0] wd,
                              input int e_acc, input int e_int, input int e_rdy, input int chk_d,
                              input logic [31:0] e_d);
    vec_t v;
    v.uw = 1'(uw); v.idx = IW'(idx); v.ud = ud; v.done = 1'(done);
    v.rd = 1'(rd); v.wr = 1'(wr); v.addr = (IW+1)'(addr); v.wd = wd;
    v.e_acc = 1'(e_acc); v.e_int = 1'(e_int); v.e_rdy = 1'(e_rdy);
    v.chk_d = 1'(chk_d); v.e_d = e_d;
    return v;
  endfunction

  logic [31:0] rdat;
  int          lat;

  initial begin
    // uw idx ud done | rd wr addr wd | acc int rdy chkd data
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, i, 32'hA0 + i, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0,     0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 'h100, 0, 0, 1, 1, 1, 32'h0004_0001));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,     0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 'h000, 0, 0, 1, 1, 1, 32'hA0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,     0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 'h003, 0, 0, 1, 1, 1, 32'hA3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,     0, 0, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, i, 32'h55, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0,     0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 'h100, 0, 0, 1, 1, 1, 32'h0004_0101));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,     0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 'h000, 0, 0, 1, 1, 1, 32'hA0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,     0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 'h101, 1, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,     0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 'h100, 0, 1, 0, 1, 1, 32'h0004_0100));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,     0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 'h100, 32'hFFFF_FFFF, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,     0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 'h101, 0, 1, 0, 1, 1, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,     0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 'h100, 0, 1, 0, 1, 1, 32'h0004_0100));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,     0, 1, 0, 0, 0, 0));

    // ---- reset state
    step(); step();
    chk("reset_accept", 32'(usb_accept), 32'd1);
    chk("reset_int",    32'(interrupt),  32'd0);
    chk("reset_ready",  32'(cpu_ready),  32'd0);
    chk("reset_rdata",  cpu_read_data,   32'd0);
    reset_n = 1'b1;
    step();

    // ---- table
    foreach (tbl[i]) begin
      usb_write = tbl[i].uw; usb_write_index = tbl[i].idx; usb_write_data = tbl[i].ud;
      usb_packet_done = tbl[i].done; cpu_read = tbl[i].rd; cpu_write = tbl[i].wr;
      cpu_address = tbl[i].addr; cpu_write_data = tbl[i].wd;
      step();
      chk($sformatf("row%0d_accept", i), 32'(usb_accept), 32'(tbl[i].e_acc));
      chk($sformatf("row%0d_int", i),    32'(interrupt),  32'(tbl[i].e_int));
      chk($sformatf("row%0d_ready", i),  32'(cpu_ready),  32'(tbl[i].e_rdy));
      if (tbl[i].chk_d) chk($sformatf("row%0d_rdata", i), cpu_read_data, tbl[i].e_d);
    end
    usb_write = 0; usb_packet_done = 0; cpu_read = 0; cpu_write = 0;

    // ---- receiver/CPU conflict in RECEIVING
    usb_write = 1; usb_write_index = 8'd4; usb_write_data = 32'h11; step(); usb_write = 0;
    step();
    usb_write = 1; usb_write_index = 8'd5; usb_write_data = 32'hDEAD_BEEF;
    cpu_read = 1; cpu_address = 9'h005;
    step(); usb_write = 0;
    chk("stall_ready_low", 32'(cpu_ready), 32'd0);
    step();
    chk("stall_ready_high", 32'(cpu_ready), 32'd1);
    chk("stall_rdata", cpu_read_data, 32'hDEAD_BEEF);
    cpu_read = 0; step();
    usb_packet_done = 1; step(); usb_packet_done = 0;
    chk("conf_full_int", 32'(interrupt), 32'd1);
    cpu_xfer(0, 9'h100, 0, rdat, lat);
    chk("conf_status", rdat, 32'h0002_0101);
    chk("conf_status_lat", 32'(lat), 32'd1);
    cpu_xfer(1, 9'h101, 32'h3, rdat, lat);
    cpu_xfer(0, 9'h100, 0, rdat, lat);
    chk("rel_clr_status", rdat, 32'h0002_0000);

    // ---- done with no writes, release+done together, clear dropped
    usb_packet_done = 1; step(); usb_packet_done = 0;
    chk("empty_int", 32'(interrupt), 32'd1);
    chk("empty_accept", 32'(usb_accept), 32'd0);
    cpu_xfer(0, 9'h100, 0, rdat, lat);
    chk("empty_status", rdat, 32'h0000_0001);
    cpu_write = 1; cpu_address = 9'h101; cpu_write_data = 32'h1; usb_packet_done = 1;
    step(); usb_packet_done = 0;
    chk("reldone_ready", 32'(cpu_ready), 32'd1);
    cpu_write = 0;
    chk("reldone_accept", 32'(usb_accept), 32'd1);
    chk("reldone_int", 32'(interrupt), 32'd0);
    step();
    cpu_xfer(0, 9'h100, 0, rdat, lat);
    chk("reldone_status", rdat, 32'h0000_0100);
    cpu_xfer(1, 9'h101, 32'h2, rdat, lat);
    cpu_xfer(0, 9'h100, 0, rdat, lat);
    chk("clrdrop_status", rdat, 32'h0);

    // ---- length saturation
    for (int i = 0; i < 300; i++) begin
      usb_write = 1; usb_write_index = IW'(i); usb_write_data = 32'h5A00_0000 + 32'(i);
      m_mem[i % DEPTH] = 32'h5A00_0000 + 32'(i);
      step();
    end
    usb_write = 0; usb_packet_done = 1; step(); usb_packet_done = 0;
    cpu_xfer(0, 9'h100, 0, rdat, lat);
    chk("sat_status", rdat, 32'h0100_0001);
    cpu_xfer(0, 9'h00A, 0, rdat, lat);
    chk("sat_word10", rdat, 32'h5A00_0000 + 32'd266);
    cpu_xfer(1, 9'h101, 32'h1, rdat, lat);
    m_state = 0; m_len = DEPTH; m_drop = 0;

    // ---- randomized operations against the model
    for (int it = 0; it < 250; it++) begin
      int op, idx, ridx, elat;
      logic [31:0] d, ed;
      bit dn, cpu, cwr, chkd;
      logic [IW:0] ca;
      logic [31:0] cwd;
      op = $urandom_range(0, 7); idx = $urandom_range(0, DEPTH-1);
      ridx = ($urandom_range(0, 1) == 1) ? idx : $urandom_range(0, DEPTH-1);
      d = $urandom(); dn = ($urandom_range(0, 3) == 0);
      cpu = 0; cwr = 0; chkd = 0; ca = '0; cwd = '0; ed = '0; elat = 1;
      case (op)
        0: begin
          usb_write = 1; usb_write_index = IW'(idx); usb_write_data = d; usb_packet_done = dn;
          m_usb(1, idx, d, dn, 0);
        end
        1: begin usb_packet_done = 1; m_usb(0, 0, '0, 1, 0); end
        2: begin cpu = 1; ca = (IW+1)'(ridx); chkd = 1; ed = m_mem[ridx]; end
        3: begin cpu = 1; cwr = 1; ca = (IW+1)'(idx); cwd = d; m_mem[idx] = d; end
        4: begin cpu = 1; ca = 9'h100; chkd = 1; ed = m_status(); end
        5: begin
          cpu = 1; cwr = 1; ca = 9'h101; cwd = 32'($urandom_range(0, 3));
          if (cwd[1]) m_drop = 0;
          m_usb(0, 0, '0, 0, cwd[0]);
        end
        6: begin
          elat = (m_state != 2) ? 2 : 1;
          usb_write = 1; usb_write_index = IW'(idx); usb_write_data = d;
          m_usb(1, idx, d, 0, 0);
          cpu = 1; ca = (IW+1)'(ridx); chkd = 1; ed = m_mem[ridx];
        end
        default: begin
          cpu = 1; cwr = 1; ca = 9'h101; cwd = 32'h1; usb_packet_done = 1;
          m_usb(0, 0, '0, 1, 1);
        end
      endcase
      cpu_write = cpu && cwr; cpu_read = cpu && !cwr; cpu_address = ca; cpu_write_data = cwd;
      step();
      usb_write = 0; usb_packet_done = 0;
      if (cpu) begin
        lat = 1;
        while (!cpu_ready && lat < 5) begin step(); lat++; end
        rdat = cpu_read_data;
        cpu_read = 0; cpu_write = 0;
        chk($sformatf("rnd%0d_op%0d_lat", it, op), 32'(lat), 32'(elat));
        if (chkd) chk($sformatf("rnd%0d_op%0d_rdata", it, op), rdat, ed);
      end
      chk($sformatf("rnd%0d_accept", it), 32'(usb_accept), 32'(m_state == 0));
      chk($sformatf("rnd%0d_int", it),    32'(interrupt),  32'(m_state == 2));
      step();
    end

    // ---- make sure we are receiving, then reset mid-packet
    cpu_xfer(1, 9'h101, 32'h1, rdat, lat);
    usb_write = 1; usb_write_index = 8'd0; usb_write_data = 32'h1; step();
    usb_write_index = 8'd1; step(); usb_write = 0;
    chk("prerst_accept", 32'(usb_accept), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_accept", 32'(usb_accept), 32'd1);
    chk("midrst_int",    32'(interrupt),  32'd0);
    step(); step();
    reset_n = 1'b1;
    step();
    cpu_xfer(0, 9'h100, 0, rdat, lat);
    chk("postrst_status", rdat, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
